sys_arr_ctrl: RTL and testbench

SYS_ARR_CTRL -- requirements
Module: sys_arr_ctrl

---
 rtl/sys_arr_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sys_arr_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arr_ctrl.sv
// sys_arr_ctrl: sequencer for a 2x2 output-stationary systolic array.
// Latches A/B, feeds them skewed into the array, then captures C.
module sys_arr_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DATA_W-1:0] a_in,
    input  logic [4*DATA_W-1:0] b_in,
    output logic                in_ready,
    input  logic                abort,
    output logic [DATA_W-1:0]   a_row0,
    output logic [DATA_W-1:0]   a_row1,
    output logic [DATA_W-1:0]   b_col0,
    output logic [DATA_W-1:0]   b_col1,
    output logic                pe_clr,
    output logic                pe_en,
    input  logic [4*ACC_W-1:0]  c_in,
    output logic [4*ACC_W-1:0]  c_out,
    output logic                out_valid,
    input  logic                out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } state_t;

    state_t state, state_nx;
    logic [1:0] k, k_nx;
    logic [4*DATA_W-1:0] a_q, b_q;
    logic [4*ACC_W-1:0]  c_q;
    logic load, cap;

    logic [DATA_W-1:0] a00, a01, a10, a11;
    logic [DATA_W-1:0] b00, b01, b10, b11;

    assign a00 = a_q[0*DATA_W +: DATA_W];
    assign a01 = a_q[1*DATA_W +: DATA_W];
    assign a10 = a_q[2*DATA_W +: DATA_W];
    assign a11 = a_q[3*DATA_W +: DATA_W];
    assign b00 = b_q[0*DATA_W +: DATA_W];
    assign b01 = b_q[1*DATA_W +: DATA_W];
    assign b10 = b_q[2*DATA_W +: DATA_W];
    assign b11 = b_q[3*DATA_W +: DATA_W];

    assign c_out = c_q;

    // Next-state, step counter and all array-facing outputs.
    always_comb begin
        state_nx  = state;
        k_nx      = k;
        load      = 1'b0;
        cap       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        pe_clr    = 1'b0;
        pe_en     = 1'b0;
        a_row0    = '0;
        a_row1    = '0;
        b_col0    = '0;
        b_col1    = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                pe_clr   = 1'b1;
                k_nx     = 2'd0;
                state_nx = FEED;
            end
            FEED: begin
                pe_en = 1'b1;
                // Row 1 / column 1 lag row 0 / column 0 by one step.
                if (k == 2'd0) begin
                    a_row0 = a00;
                    b_col0 = b00;
                end else if (k == 2'd1) begin
                    a_row0 = a01;
                    a_row1 = a10;
                    b_col0 = b10;
                    b_col1 = b01;
                end else begin
                    a_row1 = a11;
                    b_col1 = b11;
                end
                if (k == 2'd2) begin
                    k_nx     = 2'd0;
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + 2'd1;
                end
            end
            DRAIN: begin
                pe_en = 1'b1;
                if (k == 2'd1) begin
                    k_nx     = 2'd0;
                    state_nx = CAPTURE;
                end else begin
                    k_nx = k + 2'd1;
                end
            end
            CAPTURE: begin
                cap      = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                k_nx     = 2'd0;
            end
        endcase
        // Abort wins over start, capture and the output handshake.
        if (abort) begin
            state_nx = IDLE;
            k_nx     = 2'd0;
            load     = 1'b0;
            cap      = 1'b0;
        end
    end

    // State and step counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    // Operand latch, loaded only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    // Result register, captured at the end of CAPTURE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= '0;
        end else if (cap) begin
            c_q <= c_in;
        end
    end

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// tb_sys_arr_ctrl: directed bench for sys_arr_ctrl driving a
// behavioural 2x2 systolic array as the c_in source.
module tb_sys_arr_ctrl;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4*DW-1:0] a_in, b_in;
    logic          in_ready;
    logic          abort;
    logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
    logic          pe_clr, pe_en;
    logic [4*AW-1:0] c_in, c_out;
    logic          out_valid;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    sys_arr_ctrl #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a_in(a_in),
        .b_in(b_in),
        .in_ready(in_ready),
        .abort(abort),
        .a_row0(a_row0),
        .a_row1(a_row1),
        .b_col0(b_col0),
        .b_col1(b_col1),
        .pe_clr(pe_clr),
        .pe_en(pe_en),
        .c_in(c_in),
        .c_out(c_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference output-stationary array.
    logic signed [DW-1:0] ah00, ah10, bv00, bv01;
    logic signed [AW-1:0] acc00, acc01, acc10, acc11;
    logic signed [DW-1:0] ia00, ia01, ia10, ia11;
    logic signed [DW-1:0] ib00, ib01, ib10, ib11;
    logic signed [AW-1:0] p00, p01, p10, p11;

    assign ia00 = a_row0;
    assign ia01 = ah00;
    assign ia10 = a_row1;
    assign ia11 = ah10;
    assign ib00 = b_col0;
    assign ib01 = b_col1;
    assign ib10 = bv00;
    assign ib11 = bv01;
    assign p00 = AW'(ia00) * AW'(ib00);
    assign p01 = AW'(ia01) * AW'(ib01);
    assign p10 = AW'(ia10) * AW'(ib10);
    assign p11 = AW'(ia11) * AW'(ib11);
    assign c_in = {acc11, acc10, acc01, acc00};

    always_ff @(posedge clk) begin
        if (reset || pe_clr) begin
            ah00 <= '0; ah10 <= '0; bv00 <= '0; bv01 <= '0;
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
        end else if (pe_en) begin
            ah00 <= ia00; ah10 <= ia10;
            bv00 <= ib00; bv01 <= ib01;
            acc00 <= acc00 + p00;
            acc01 <= acc01 + p01;
            acc10 <= acc10 + p10;
            acc11 <= acc11 + p11;
        end
    end

    function automatic logic [4*DW-1:0] pk(input int m00, input int m01,
                                           input int m10, input int m11);
        return {DW'(m11), DW'(m10), DW'(m01), DW'(m00)};
    endfunction

    function automatic logic [4*AW-1:0] pc(input int m00, input int m01,
                                           input int m10, input int m11);
        return {AW'(m11), AW'(m10), AW'(m01), AW'(m00)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a job and stop in cycle 8 (first DONE cycle).
    task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0;
        #3;
        total++;
        if ({pe_en, pe_clr, out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000", {pe_en, pe_clr, out_valid});
        end
        total++;
        if ({a_row0, a_row1, b_col0, b_col1} !== '0) begin
            bad++;
            $display("FAIL reset_feeds got=%h exp=0", {a_row0, a_row1, b_col0, b_col1});
        end
        total++;
        if (c_out !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_out got c_out=%h in_ready=%b exp 0/1", c_out, in_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [4*DW-1:0] fv[3];
        fv[0] = {16'd1, 16'd0, 16'd5, 16'd0};
        fv[1] = {16'd2, 16'd3, 16'd7, 16'd6};
        fv[2] = {16'd0, 16'd4, 16'd0, 16'd8};
        a_in  = pk(1, 2, 3, 4);
        b_in  = pk(5, 6, 7, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({pe_clr, pe_en, in_ready} !== 3'b100) begin
            bad++;
            $display("FAIL clear_cycle got=%b exp=100", {pe_clr, pe_en, in_ready});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({a_row0, a_row1, b_col0, b_col1} !== fv[k] ||
                pe_en !== 1'b1 || pe_clr !== 1'b0) begin
                bad++;
                $display("FAIL feed_k%0d got=%h en=%b clr=%b exp=%h en=1 clr=0",
                         k, {a_row0, a_row1, b_col0, b_col1}, pe_en, pe_clr, fv[k]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            total++;
            if ({a_row0, a_row1, b_col0, b_col1} !== '0 || pe_en !== 1'b1) begin
                bad++;
                $display("FAIL drain_%0d got=%h en=%b exp=0 en=1",
                         d, {a_row0, a_row1, b_col0, b_col1}, pe_en);
            end
        end
        tick();
        total++;
        if ({pe_en, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL capture_cycle got=%b exp=00", {pe_en, out_valid});
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || c_out !== pc(19, 22, 43, 50)) begin
            bad++;
            $display("FAIL basic_result got v=%b c=%h exp v=1 c=%h",
                     out_valid, c_out, pc(19, 22, 43, 50));
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || c_out !== pc(19, 22, 43, 50) || pe_en !== 1'b0) begin
            bad++;
            $display("FAIL done_hold got v=%b c=%h en=%b", out_valid, c_out, pe_en);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL done_release got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_out_ready_idle();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01 || c_out !== pc(19, 22, 43, 50)) begin
            bad++;
            $display("FAIL ready_idle got v=%b r=%b c=%h", out_valid, in_ready, c_out);
        end
    endtask

    task automatic test_signed();
        run_job(pk(-1, 0, 0, -1), pk(100, -100, -32768, 32767));
        total++;
        if (out_valid !== 1'b1 || c_out !== pc(-100, 100, 32768, -32767)) begin
            bad++;
            $display("FAIL signed_result got v=%b c=%h exp v=1 c=%h",
                     out_valid, c_out, pc(-100, 100, 32768, -32767));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        a_in  = pk(1, 2, 3, 4);
        b_in  = pk(5, 6, 7, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in  = pk(9, 9, 9, 9);
        b_in  = pk(-3, 11, 2, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({a_row0, a_row1, b_col0, b_col1} !== {16'd0, 16'd4, 16'd0, 16'd8}) begin
            bad++;
            $display("FAIL ign_feed got=%h exp=%h",
                     {a_row0, a_row1, b_col0, b_col1}, {16'd0, 16'd4, 16'd0, 16'd8});
        end
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || c_out !== pc(19, 22, 43, 50)) begin
            bad++;
            $display("FAIL ign_result got v=%b c=%h exp v=1 c=%h",
                     out_valid, c_out, pc(19, 22, 43, 50));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_in  = pk(-1, 0, 0, -1);
        b_in  = pk(100, -100, -32768, 32767);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({pe_en, pe_clr, out_valid, in_ready} !== 4'b0001 ||
            {a_row0, a_row1, b_col0, b_col1} !== '0 || c_out !== '0) begin
            bad++;
            $display("FAIL mid_reset got en=%b clr=%b v=%b r=%b f=%h c=%h",
                     pe_en, pe_clr, out_valid, in_ready,
                     {a_row0, a_row1, b_col0, b_col1}, c_out);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({in_ready, pe_clr, pe_en} !== 3'b100) begin
            bad++;
            $display("FAIL mid_wait got=%b exp=100", {in_ready, pe_clr, pe_en});
        end
        run_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        total++;
        if (out_valid !== 1'b1 || c_out !== pc(19, 22, 43, 50)) begin
            bad++;
            $display("FAIL mid_rerun got v=%b c=%h exp v=1 c=%h",
                     out_valid, c_out, pc(19, 22, 43, 50));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        start = 1'b1;
        abort = 1'b1;
        a_in  = pk(-1, 0, 0, -1);
        b_in  = pk(100, -100, -32768, 32767);
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if ({in_ready, pe_clr} !== 2'b10) begin
            bad++;
            $display("FAIL abort_vs_start got=%b exp=10", {in_ready, pe_clr});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({in_ready, pe_en, out_valid} !== 3'b100 ||
            {a_row0, a_row1, b_col0, b_col1} !== '0) begin
            bad++;
            $display("FAIL abort_drain got r=%b en=%b v=%b f=%h",
                     in_ready, pe_en, out_valid, {a_row0, a_row1, b_col0, b_col1});
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0 || c_out !== pc(19, 22, 43, 50)) begin
            bad++;
            $display("FAIL abort_after got valid_cycles=%0d c=%h exp 0 c=%h",
                     seen, c_out, pc(19, 22, 43, 50));
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] mask;
        logic [27:0] exp_mask;
        int badc;
        mask     = '0;
        exp_mask = 28'(1 << 8) | 28'(1 << 17) | 28'(1 << 26);
        badc     = 0;
        a_in      = pk(-1, 0, 0, -1);
        b_in      = pk(100, -100, -32768, 32767);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        for (int c = 1; c < 28; c++) begin
            mask[c] = out_valid;
            if (out_valid === 1'b1 && c_out !== pc(-100, 100, 32768, -32767))
                badc++;
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b0;
        total++;
        if (mask !== exp_mask) begin
            bad++;
            $display("FAIL b2b_period got=%b exp=%b", mask, exp_mask);
        end
        total++;
        if (badc != 0) begin
            bad++;
            $display("FAIL b2b_data got bad_results=%0d exp=0", badc);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_abort got r=%b exp=1", in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_out_ready_idle();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
